console_writer: RTL and testbench



---
 rtl/console_writer.sv | 195 +++++++++++++++++++
 tb/tb_console_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/console_writer.sv
// console_writer: turns a byte stream from the processor into screen
// commands (set position / write glyph) for a text-mode screen controller.
// Keeps a wrapping cursor and handles newline, carriage return and backspace.
// Optional feature: define CONSOLE_CLEAR_EN to make form feed (0x0C) clear
// the whole screen. Without it, 0x0C is an ordinary glyph.
module console_writer #(
  parameter int         COLS        = 80,
  parameter int         ROWS        = 60,
  parameter logic [5:0] BLANK_GLYPH = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [1:0]  print,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] char,
  output logic        busy
);

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_SETPOS = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [2:0] {IDLE, SETPOS, WRITE, CLEAR_SET, CLEAR_WR} state_t;

  state_t          state_reg;
  logic [XW-1:0]   cur_x_reg;
  logic [YW-1:0]   cur_y_reg;
  logic [5:0]      glyph_reg;
  logic            back_reg;    // current write is a backspace erase
  logic [1:0]      print_reg;
  logic [31:0]     x_reg;
  logic [31:0]     y_reg;
  logic [31:0]     char_reg;

  logic [XW-1:0]   adv_x;
  logic [YW-1:0]   adv_y;
  logic [YW-1:0]   nl_y;
  logic [XW-1:0]   back_x;
  logic [YW-1:0]   back_y;
  logic            at_origin;

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign print    = print_reg;
  assign x        = x_reg;
  assign y        = y_reg;
  assign char     = char_reg;

  // Cursor neighbours: next cell (advance), next row (newline), previous cell (backspace)
  always_comb begin
    nl_y      = (cur_y_reg == Y_LAST) ? '0 : cur_y_reg + YW'(1);
    adv_x     = cur_x_reg + XW'(1);
    adv_y     = cur_y_reg;
    if (cur_x_reg == X_LAST) begin
      adv_x = '0;
      adv_y = nl_y;
    end
    back_x    = cur_x_reg - XW'(1);
    back_y    = cur_y_reg;
    if (cur_x_reg == '0) begin
      back_x = X_LAST;
      back_y = cur_y_reg - YW'(1);  // only used when not at the origin
    end
    at_origin = (cur_x_reg == '0) && (cur_y_reg == '0);
  end

`ifdef CONSOLE_CLEAR_EN
  logic [XW-1:0] clr_x;
  logic [YW-1:0] clr_y;
  logic [XW-1:0] clr_nx;
  logic [YW-1:0] clr_ny;
  logic          clr_last;

  // The clear sweep walks the screen using the position output itself as its counter
  always_comb begin
    clr_x    = x_reg[XW-1:0];
    clr_y    = y_reg[YW-1:0];
    clr_last = (clr_x == X_LAST) && (clr_y == Y_LAST);
    clr_nx   = clr_x + XW'(1);
    clr_ny   = clr_y;
    if (clr_x == X_LAST) begin
      clr_nx = '0;
      clr_ny = clr_y + YW'(1);
    end
  end
`endif

  // Command sequencer: accepts a byte in IDLE, then emits SETPOS/WRITE pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cur_x_reg <= '0;
      cur_y_reg <= '0;
      glyph_reg <= '0;
      back_reg  <= 1'b0;
      print_reg <= CMD_IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      char_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            case (in_data)
              8'h0A: begin
                cur_x_reg <= '0;
                cur_y_reg <= nl_y;
              end
              8'h0D: begin
                cur_x_reg <= '0;
              end
              8'h08: begin
                if (!at_origin) begin
                  state_reg <= SETPOS;
                  print_reg <= CMD_SETPOS;
                  x_reg     <= 32'(back_x);
                  y_reg     <= 32'(back_y);
                  glyph_reg <= BLANK_GLYPH;
                  back_reg  <= 1'b1;
                end
              end
`ifdef CONSOLE_CLEAR_EN
              8'h0C: begin
                state_reg <= CLEAR_SET;
                print_reg <= CMD_SETPOS;
                x_reg     <= '0;
                y_reg     <= '0;
              end
`endif
              default: begin
                state_reg <= SETPOS;
                print_reg <= CMD_SETPOS;
                x_reg     <= 32'(cur_x_reg);
                y_reg     <= 32'(cur_y_reg);
                glyph_reg <= in_data[5:0];
                back_reg  <= 1'b0;
              end
            endcase
          end
        end
        SETPOS: begin
          state_reg <= WRITE;
          print_reg <= CMD_WRITE;
          char_reg  <= 32'(glyph_reg);
        end
        WRITE: begin
          state_reg <= IDLE;
          print_reg <= CMD_IDLE;
          if (back_reg) begin
            // Backspace leaves the cursor on the erased cell
            cur_x_reg <= x_reg[XW-1:0];
            cur_y_reg <= y_reg[YW-1:0];
          end else begin
            cur_x_reg <= adv_x;
            cur_y_reg <= adv_y;
          end
        end
`ifdef CONSOLE_CLEAR_EN
        CLEAR_SET: begin
          state_reg <= CLEAR_WR;
          print_reg <= CMD_WRITE;
          char_reg  <= 32'(BLANK_GLYPH);
        end
        CLEAR_WR: begin
          if (clr_last) begin
            state_reg <= IDLE;
            print_reg <= CMD_IDLE;
            cur_x_reg <= '0;
            cur_y_reg <= '0;
          end else begin
            state_reg <= CLEAR_SET;
            print_reg <= CMD_SETPOS;
            x_reg     <= 32'(clr_nx);
            y_reg     <= 32'(clr_ny);
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          print_reg <= CMD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_console_writer.sv
// Testbench for console_writer: directed scenarios plus random byte stream,
// every cycle checked against a cursor/command model kept in the bench.
module tb_console_writer;

  localparam int         COLS  = 80;
  localparam int         ROWS  = 60;
  localparam logic [5:0] BLANK = 6'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic [1:0]  print;
  logic [31:0] x, y, char;
  logic        busy;

  console_writer #(.COLS(COLS), .ROWS(ROWS), .BLANK_GLYPH(BLANK)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .print(print), .x(x), .y(y), .char(char), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pr;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
    logic        busy;
    logic        rdy;
  } exp_t;

  // Model state: cursor, values the outputs hold while idle, pending cycles
  int    m_cx = 0, m_cy = 0;
  int    m_lx = 0, m_ly = 0, m_lch = 0;
  exp_t  q[$];
  exp_t  ls[$];   // cycles produced by the most recent accepted byte
  int    vectors = 0;
  int    miscompares = 0;

  function automatic void model_reset();
    q.delete();
    m_cx = 0; m_cy = 0; m_lx = 0; m_ly = 0; m_lch = 0;
  endfunction

  function automatic void push_pair(int px, int py, int glyph);
    exp_t e;
    e = '{2'b01, 32'(px), 32'(py), 32'(m_lch), 1'b1, 1'b0};
    q.push_back(e); ls.push_back(e);
    e = '{2'b10, 32'(px), 32'(py), 32'(glyph), 1'b1, 1'b0};
    q.push_back(e); ls.push_back(e);
    m_lx = px; m_ly = py; m_lch = glyph;
  endfunction

  // Returns the number of busy cycles the byte causes
  function automatic int model_accept(logic [7:0] b);
    int idx;
    ls.delete();
    idx = m_cy * COLS + m_cx;
    if (b == 8'h0A) begin
      m_cx = 0; m_cy = (m_cy + 1) % ROWS;
    end else if (b == 8'h0D) begin
      m_cx = 0;
    end else if (b == 8'h08) begin
      if (idx != 0) begin
        idx = idx - 1;
        push_pair(idx % COLS, idx / COLS, int'(BLANK));
        m_cx = idx % COLS; m_cy = idx / COLS;
      end
`ifdef CONSOLE_CLEAR_EN
    end else if (b == 8'h0C) begin
      for (int i = 0; i < COLS * ROWS; i++) push_pair(i % COLS, i / COLS, int'(BLANK));
      m_cx = 0; m_cy = 0;
`endif
    end else begin
      push_pair(m_cx, m_cy, int'(b[5:0]));
      idx = (idx + 1) % (COLS * ROWS);
      m_cx = idx % COLS; m_cy = idx / COLS;
    end
    return ls.size();
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    exp_t e;
    if (rst) e = '{2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1};
    else if (q.size() > 0) e = q.pop_front();
    else e = '{2'b00, 32'(m_lx), 32'(m_ly), 32'(m_lch), 1'b0, 1'b1};
    vectors++;
    if (print !== e.pr || x !== e.x || y !== e.y || char !== e.ch ||
        busy !== e.busy || in_ready !== e.rdy) begin
      miscompares++;
      $display("FAIL cycle t=%0t: got print=%b x=%0d y=%0d char=%0d busy=%b rdy=%b expected print=%b x=%0d y=%0d char=%0d busy=%b rdy=%b",
               $time, print, x, y, char, busy, in_ready, e.pr, e.x, e.y, e.ch, e.busy, e.rdy);
    end
  end

  // Offer one byte, keep in_valid high with junk data while busy
  task automatic send(input logic [7:0] b);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = b;
    @(posedge clk);
    n = model_accept(b);
    #1;
    in_data  = 8'($urandom);
    in_valid = (n > 0);
    repeat (n) @(posedge clk);
    #1 in_valid = 1'b0;
    $display("byte 0x%02h: %0d busy cycles, cursor now (%0d,%0d)", b, n, m_cx, m_cy);
  endtask

  function automatic logic [7:0] printable();
    return 8'(8'h20 + $urandom_range(0, 8'h5E));
  endfunction

  initial begin
    logic [7:0] b;
    int r;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    model_reset();

    // First glyph after reset
    send(8'h41);
    chk("first_len", 32'(ls.size()), 2);
    chk("first_set_cmd", 32'(ls[0].pr), 1);
    chk("first_set_x", ls[0].x, 0);
    chk("first_set_y", ls[0].y, 0);
    chk("first_wr_cmd", 32'(ls[1].pr), 2);
    chk("first_wr_char", ls[1].ch, 1);
    chk("first_cursor", 32'(m_cy * 1000 + m_cx), 1);

    // Last cell wraps to the origin
    send(8'h0D);
    for (int i = 0; i < 59; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(printable());
    send(8'h05);
    chk("wrap_x", ls[0].x, 79);
    chk("wrap_y", ls[0].y, 59);
    chk("wrap_char", ls[1].ch, 5);
    chk("wrap_cursor", 32'(m_cy * 1000 + m_cx), 0);

    // Backspace across a row boundary, then at the origin
    for (int i = 0; i < 3; i++) send(8'h0A);
    send(8'h08);
    chk("bs_x", ls[0].x, 79);
    chk("bs_y", ls[0].y, 2);
    chk("bs_char", ls[1].ch, 32'(BLANK));
    chk("bs_cursor", 32'(m_cy * 1000 + m_cx), 2079);
    send(8'h0D);
    for (int i = 0; i < 58; i++) send(8'h0A);
    send(8'h08);
    chk("bs_origin_len", 32'(ls.size()), 0);
    chk("bs_origin_cursor", 32'(m_cy * 1000 + m_cx), 0);

    // CR then LF: no commands
    for (int i = 0; i < 4; i++) send(8'h0A);
    for (int i = 0; i < 10; i++) send(printable());
    send(8'h0D);
    chk("cr_len", 32'(ls.size()), 0);
    send(8'h0A);
    chk("lf_len", 32'(ls.size()), 0);
    chk("crlf_cursor", 32'(m_cy * 1000 + m_cx), 5000);

    // Random mix of control codes and glyphs with idle gaps
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) b = 8'h0A;
      else if (r < 14) b = 8'h0D;
      else if (r < 26) b = 8'h08;
      else b = 8'($urandom);
`ifdef CONSOLE_CLEAR_EN
      if (b == 8'h0C) b = 8'h4C;
`endif
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(b);
    end

`ifdef CONSOLE_CLEAR_EN
    send(8'h0C);
    chk("clear_len", 32'(ls.size()), 2 * COLS * ROWS);
    chk("clear_last_x", ls[2 * COLS * ROWS - 1].x, 79);
    chk("clear_last_y", ls[2 * COLS * ROWS - 1].y, 59);
    chk("clear_cursor", 32'(m_cy * 1000 + m_cx), 0);
`else
    send(8'h0C);
    chk("ff_glyph", ls[1].ch, 12);
`endif

    // Reset during the WRITE cycle aborts the write
    send(8'h0A);
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h33;
    @(posedge clk);
    r = model_accept(8'h33);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("abort_print", 32'(print), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(in_ready), 1);
    chk("abort_x", x, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    send(8'h07);
    chk("after_abort_x", ls[0].x, 0);
    chk("after_abort_y", ls[0].y, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
